// File: rtl/segment_sequencer.sv
// Segment sequencer: a staging bank feeds a DEPTH-deep queue of oscillator segments
// (amp/offset/phaseword per channel plus a duration) played back-to-back, optionally looped.
module segment_sequencer #(
    parameter int NCH   = 64,
    parameter int PW    = 16,
    parameter int TW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [1:0]               wr_field,
    input  logic [$clog2(NCH)-1:0]   wr_chan,
    input  logic [PW-1:0]            wr_data,
    input  logic [TW-1:0]            seg_time,
    input  logic                     commit,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     flush,
    input  logic                     loop_en,
    output logic [NCH*PW-1:0]        active_amps,
    output logic [NCH*PW-1:0]        active_offsets,
    output logic [NCH*PW-1:0]        active_phasewords,
    output logic [TW-1:0]            active_time,
    output logic                     bank_reset,
    output logic                     running,
    output logic                     seg_done,
    output logic                     seq_done,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_full,
    output logic                     q_empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = NCH * PW;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state;
    logic [BW-1:0]   stage_amp;
    logic [BW-1:0]   stage_off;
    logic [BW-1:0]   stage_phw;
    logic [BW-1:0]   q_amp  [DEPTH];
    logic [BW-1:0]   q_off  [DEPTH];
    logic [BW-1:0]   q_phw  [DEPTH];
    logic [TW-1:0]   q_time [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;

    logic            q_avail;
    logic            seg_end;
    logic            load_now;
    logic            loop_push;
    logic            commit_ok;
    logic [AW-1:0]   commit_idx;

    // A load happens on the edge that enters LOAD, so the LOAD cycle already shows the
    // new segment; a flush in the same cycle makes the queue count as empty.
    always_comb begin
        q_avail    = (q_count != '0) && !flush;
        seg_end    = (state != IDLE) && (active_time == '0);
        load_now   = !abort && q_avail && (((state == IDLE) && start) || seg_end);
        loop_push  = load_now && loop_en;
        commit_ok  = commit && !flush &&
                     ((q_count - CW'(load_now) + CW'(loop_push)) < CW'(DEPTH));
        commit_idx = loop_push ? (tail + AW'(1)) : tail;
    end

    assign q_full  = (q_count == CW'(DEPTH));
    assign q_empty = (q_count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_amp <= '0;
            stage_off <= '0;
            stage_phw <= '0;
        end else if (wr_en && (int'(wr_chan) < NCH)) begin
            case (wr_field)
                2'd0:    stage_amp[int'(wr_chan)*PW +: PW] <= wr_data;
                2'd1:    stage_off[int'(wr_chan)*PW +: PW] <= wr_data;
                2'd2:    stage_phw[int'(wr_chan)*PW +: PW] <= wr_data;
                default: ;
            endcase
        end
    end

    // Queue storage and bookkeeping; a looped entry goes in ahead of a same-cycle commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_amp[i]  <= '0;
                q_off[i]  <= '0;
                q_phw[i]  <= '0;
                q_time[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            q_count  <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            q_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (loop_push) begin
                q_amp[tail]  <= q_amp[head];
                q_off[tail]  <= q_off[head];
                q_phw[tail]  <= q_phw[head];
                q_time[tail] <= q_time[head];
            end
            if (commit_ok) begin
                q_amp[commit_idx]  <= stage_amp;
                q_off[commit_idx]  <= stage_off;
                q_phw[commit_idx]  <= stage_phw;
                q_time[commit_idx] <= seg_time;
            end
            if (commit && !commit_ok) begin
                overflow <= 1'b1;
            end
            head    <= head + AW'(load_now);
            tail    <= tail + AW'(loop_push) + AW'(commit_ok);
            q_count <= q_count - CW'(load_now) + CW'(loop_push) + CW'(commit_ok);
        end
    end

    // Playback FSM; every output it drives is a register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            active_amps       <= '0;
            active_offsets    <= '0;
            active_phasewords <= '0;
            active_time       <= '0;
            bank_reset        <= 1'b0;
            running           <= 1'b0;
            seg_done          <= 1'b0;
            seq_done          <= 1'b0;
        end else begin
            bank_reset <= 1'b0;
            seg_done   <= 1'b0;
            seq_done   <= 1'b0;
            if (abort) begin
                state             <= IDLE;
                active_amps       <= '0;
                active_offsets    <= '0;
                active_phasewords <= '0;
                active_time       <= '0;
                running           <= 1'b0;
            end else if (load_now) begin
                state             <= LOAD;
                active_amps       <= q_amp[head];
                active_offsets    <= q_off[head];
                active_phasewords <= q_phw[head];
                active_time       <= q_time[head];
                bank_reset        <= 1'b1;
                running           <= 1'b1;
                seg_done          <= (state != IDLE);
            end else if (seg_end) begin
                state             <= IDLE;
                active_amps       <= '0;
                active_offsets    <= '0;
                active_phasewords <= '0;
                active_time       <= '0;
                running           <= 1'b0;
                seq_done          <= 1'b1;
            end else if (state != IDLE) begin
                state       <= RUN;
                active_time <= active_time - TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_segment_sequencer.sv
// Directed bench for segment_sequencer: a queue-level model checked every cycle plus
// hand-computed expectations at key points of each scenario.
module tb_segment_sequencer;

    localparam int NCH   = 64;
    localparam int PW    = 16;
    localparam int TW    = 16;
    localparam int DEPTH = 4;
    localparam int BW    = NCH * PW;

    logic                    clk;
    logic                    reset_n;
    logic                    wr_en;
    logic [1:0]              wr_field;
    logic [$clog2(NCH)-1:0]  wr_chan;
    logic [PW-1:0]           wr_data;
    logic [TW-1:0]           seg_time;
    logic                    commit;
    logic                    start;
    logic                    abort;
    logic                    flush;
    logic                    loop_en;
    logic [BW-1:0]           active_amps;
    logic [BW-1:0]           active_offsets;
    logic [BW-1:0]           active_phasewords;
    logic [TW-1:0]           active_time;
    logic                    bank_reset;
    logic                    running;
    logic                    seg_done;
    logic                    seq_done;
    logic [$clog2(DEPTH):0]  q_count;
    logic                    q_full;
    logic                    q_empty;
    logic                    overflow;

    segment_sequencer #(.NCH(NCH), .PW(PW), .TW(TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_field(wr_field),
        .wr_chan(wr_chan), .wr_data(wr_data), .seg_time(seg_time), .commit(commit),
        .start(start), .abort(abort), .flush(flush), .loop_en(loop_en),
        .active_amps(active_amps), .active_offsets(active_offsets),
        .active_phasewords(active_phasewords), .active_time(active_time),
        .bank_reset(bank_reset), .running(running), .seg_done(seg_done),
        .seq_done(seq_done), .q_count(q_count), .q_full(q_full), .q_empty(q_empty),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [BW-1:0] amp;
        logic [BW-1:0] off;
        logic [BW-1:0] phw;
        logic [TW-1:0] t;
    } seg_t;

    // Model: a queue of whole segments and a count of cycles still to show.
    seg_t          mq[$];
    seg_t          m_cur;
    seg_t          m_s;
    bit            m_play;
    bit            m_ended;
    int            m_left;
    bit            m_bank, m_sd, m_qd, m_ovf;
    logic [BW-1:0] m_amp, m_off, m_phw;

    task automatic model_step();
        if (!reset_n) begin
            mq.delete();
            m_play = 0; m_cur = '0; m_left = 0;
            m_bank = 0; m_sd = 0; m_qd = 0; m_ovf = 0;
            m_amp = '0; m_off = '0; m_phw = '0;
        end else begin
            m_ended = m_play && (m_left == 0);
            m_bank = 0; m_sd = 0; m_qd = 0;
            if (abort) begin
                m_play = 0;
            end else if (mq.size() > 0 && !flush && ((!m_play && start) || m_ended)) begin
                m_s = mq.pop_front();
                if (loop_en) mq.push_back(m_s);
                m_sd = m_play;
                m_cur = m_s;
                m_left = int'(m_s.t);
                m_play = 1;
                m_bank = 1;
            end else if (m_ended) begin
                m_qd = 1;
                m_play = 0;
            end else if (m_play) begin
                m_left--;
            end
            if (flush) begin
                mq.delete();
                m_ovf = 0;
            end else if (commit) begin
                if (mq.size() < DEPTH) mq.push_back('{m_amp, m_off, m_phw, seg_time});
                else m_ovf = 1;
            end
            if (wr_en) begin
                case (wr_field)
                    2'd0: m_amp[int'(wr_chan)*PW +: PW] = wr_data;
                    2'd1: m_off[int'(wr_chan)*PW +: PW] = wr_data;
                    2'd2: m_phw[int'(wr_chan)*PW +: PW] = wr_data;
                    default: ;
                endcase
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            for (int c = 0; c < NCH; c++) begin
                if (act[c*PW +: PW] !== exp_v[c*PW +: PW]) begin
                    $display("FAIL %s ch%0d: got %h expected %h", name, c,
                             act[c*PW +: PW], exp_v[c*PW +: PW]);
                    break;
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (reset_n === 1'b1) begin
            chk_bus("cyc_amps", active_amps,       m_play ? m_cur.amp : '0);
            chk_bus("cyc_offs", active_offsets,    m_play ? m_cur.off : '0);
            chk_bus("cyc_phws", active_phasewords, m_play ? m_cur.phw : '0);
            chk("cyc_time",     64'(active_time), m_play ? 64'(m_left) : 64'd0);
            chk("cyc_bank",     64'(bank_reset), 64'(m_bank));
            chk("cyc_running",  64'(running),    64'(m_play));
            chk("cyc_seg_done", 64'(seg_done),   64'(m_sd));
            chk("cyc_seq_done", 64'(seq_done),   64'(m_qd));
            chk("cyc_q_count",  64'(q_count),    64'(mq.size()));
            chk("cyc_q_full",   64'(q_full),     64'(mq.size() == DEPTH));
            chk("cyc_q_empty",  64'(q_empty),    64'(mq.size() == 0));
            chk("cyc_overflow", 64'(overflow),   64'(m_ovf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] f, input int ch, input logic [PW-1:0] d);
        wr_en = 1; wr_field = f; wr_chan = ($clog2(NCH))'(ch); wr_data = d;
        step();
        wr_en = 0;
    endtask

    task automatic do_commit(input logic [TW-1:0] t);
        seg_time = t; commit = 1;
        step();
        commit = 0;
    endtask

    logic [15:0] exp_a2 [6];
    logic [15:0] obs_a2 [6];
    logic [5:0]  obs_bank, obs_seg, obs_seq, obs_run;
    int          hold, nbank, nseq, errs_pat, errs_q, seen_seq;

    initial begin
        reset_n = 0; wr_en = 0; wr_field = 0; wr_chan = 0; wr_data = 0;
        seg_time = 0; commit = 0; start = 0; abort = 0; flush = 0; loop_en = 0;
        exp_a2 = '{16'h00A1, 16'h00A1, 16'h00A1, 16'h00B2, 16'h0000, 16'h0000};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q_empty", 64'(q_empty), 64'd1);
        chk("rst_q_count", 64'(q_count), 64'd0);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk_bus("rst_amps", active_amps, '0);
        reset_n = 1;
        step();

        // Single segment, T=3
        wr(2'd0, 0, 16'h1234);
        wr(2'd2, 63, 16'hBEEF);
        wr(2'd3, 5, 16'hDEAD);
        do_commit(16'd3);
        chk("t1_q_count_commit", 64'(q_count), 64'd1);
        chk("t1_model_qsize", 64'(mq.size()), 64'd1);
        start = 1; step(); start = 0;
        chk("t1_q_count_load", 64'(q_count), 64'd0);
        chk("t1_bank_reset", 64'(bank_reset), 64'd1);
        chk("t1_time", 64'(active_time), 64'd3);
        chk("t1_phw63", 64'(active_phasewords[63*PW +: PW]), 64'hBEEF);
        chk("t1_off5", 64'(active_offsets[5*PW +: PW]), 64'd0);
        hold = 0; nbank = 0; nseq = 0;
        for (int i = 0; i < 8; i++) begin
            if (active_amps[15:0] == 16'h1234) hold++;
            if (bank_reset) nbank++;
            if (seq_done) nseq++;
            step();
        end
        chk("t1_hold_cycles", 64'(hold), 64'd4);
        chk("t1_bank_pulses", 64'(nbank), 64'd1);
        chk("t1_seq_pulses", 64'(nseq), 64'd1);

        // Two segments T=2 then T=0, no gap
        wr(2'd0, 0, 16'h00A1);
        do_commit(16'd2);
        wr(2'd0, 0, 16'h00B2);
        do_commit(16'd0);
        start = 1; step(); start = 0;
        for (int i = 0; i < 6; i++) begin
            obs_a2[i] = active_amps[15:0];
            obs_bank[i] = bank_reset;
            obs_seg[i] = seg_done;
            obs_seq[i] = seq_done;
            obs_run[i] = running;
            step();
        end
        for (int i = 0; i < 6; i++) chk("t2_amp_seq", 64'(obs_a2[i]), 64'(exp_a2[i]));
        chk("t2_bank", 64'(obs_bank), 64'b001001);
        chk("t2_seg_done", 64'(obs_seg), 64'b001000);
        chk("t2_seq_done", 64'(obs_seq), 64'b010000);
        chk("t2_running", 64'(obs_run), 64'b001111);

        // Fill and overflow
        for (int k = 1; k <= 5; k++) begin
            do_commit(16'(k));
            if (k == 4) begin
                chk("t3_full_after4", 64'(q_full), 64'd1);
                chk("t3_count_after4", 64'(q_count), 64'd4);
                chk("t3_ovf_after4", 64'(overflow), 64'd0);
            end
        end
        chk("t3_ovf_after5", 64'(overflow), 64'd1);
        chk("t3_count_after5", 64'(q_count), 64'd4);
        chk("t3_model_ovf", 64'(m_ovf), 64'd1);
        flush = 1; step(); flush = 0;
        chk("t3_flush_count", 64'(q_count), 64'd0);
        chk("t3_flush_ovf", 64'(overflow), 64'd0);
        chk("t3_flush_empty", 64'(q_empty), 64'd1);

        // Looping A,A,B,B
        wr(2'd0, 0, 16'h00AA);
        do_commit(16'd1);
        wr(2'd0, 0, 16'h00BB);
        do_commit(16'd1);
        loop_en = 1;
        start = 1; step(); start = 0;
        errs_pat = 0; errs_q = 0; seen_seq = 0;
        for (int i = 0; i < 20; i++) begin
            if (active_amps[15:0] != ((((i / 2) % 2) == 0) ? 16'h00AA : 16'h00BB)) errs_pat++;
            if (q_count != 3'd2) errs_q++;
            if (seq_done) seen_seq++;
            step();
        end
        chk("t4_pattern_errs", 64'(errs_pat), 64'd0);
        chk("t4_qcount_errs", 64'(errs_q), 64'd0);
        chk("t4_seq_seen", 64'(seen_seq), 64'd0);
        abort = 1; step(); abort = 0; loop_en = 0;
        chk("t4_abort_amp0", 64'(active_amps[15:0]), 64'd0);
        chk("t4_abort_running", 64'(running), 64'd0);
        chk("t4_abort_count", 64'(q_count), 64'd2);

        // Commit during a pop with the queue full
        flush = 1; step(); flush = 0;
        for (int k = 0; k < 4; k++) begin
            wr(2'd0, 0, 16'(16'h0051 + k));
            do_commit(16'd1);
        end
        chk("t5_count_full", 64'(q_count), 64'd4);
        start = 1; step(); start = 0;
        chk("t5_load_s1", 64'(active_amps[15:0]), 64'h0051);
        chk("t5_count_load", 64'(q_count), 64'd3);
        commit = 1;
        step();
        chk("t5_refill", 64'(q_count), 64'd4);
        step();
        commit = 0;
        chk("t5_pop_commit_count", 64'(q_count), 64'd4);
        chk("t5_pop_commit_ovf", 64'(overflow), 64'd0);
        chk("t5_load_s2", 64'(active_amps[15:0]), 64'h0052);
        chk("t5_seg_done", 64'(seg_done), 64'd1);

        // Asynchronous reset in the middle of RUN
        step();
        #2 reset_n = 0;
        #1;
        chk_bus("t6_rst_amps", active_amps, '0);
        chk("t6_rst_running", 64'(running), 64'd0);
        chk("t6_rst_time", 64'(active_time), 64'd0);
        chk("t6_rst_empty", 64'(q_empty), 64'd1);
        chk("t6_rst_count", 64'(q_count), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        start = 1; step(); start = 0;
        chk("t6_start_ignored_run", 64'(running), 64'd0);
        chk("t6_start_ignored_bank", 64'(bank_reset), 64'd0);
        chk("t6_start_ignored_cnt", 64'(q_count), 64'd0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
